silife_max7219_rx: RTL and testbench
====================================

Name: silife_max7219_rx

Overview:
- Behavioural receiver for a daisy-chain of MAX7219 LED drivers, built as synthesizable RTL.
- Sits on the SPI pins (CS/LOAD, CLK, DIN) that the game-matrix display driver produces, and decodes every latched word into per-device register state.
- The 8x8 digit rows are exposed through a read port and the control registers as flat buses.
- Used for on-chip loopback self-test and as the checker in display-driver benches.

Parameters:
- NUM_DEVICES, 4, number of chained MAX7219 devices modelled; device 0 is the one nearest DIN.
- DEV_W, $clog2(NUM_DEVICES) (min 1), width of the device-select index.

Ports:
- clk  input  1  system clock; must run at least 8x faster than the SPI clock.
- reset  input  1  synchronous, active-high.
- i_cs  input  1  SPI chip select / LOAD, active-low, asynchronous to clk.
- i_sck  input  1  SPI clock, asynchronous to clk; data is sampled on the rising edge.
- i_mosi  input  1  SPI data, MSB first.
- o_dout  output  1  chain DOUT; equals the MSB of the chain shift register.
- i_rd_dev  input  DEV_W  read-port device select.
- i_rd_row  input  3  read-port row select (row 0 = digit register 0x1).
- o_rd_data  output  8  digit register contents; registered, 1-cycle latency.
- o_intensity  output  4*NUM_DEVICES  intensity registers; device d at [4d+3:4d].
- o_scan_limit  output  3*NUM_DEVICES  scan-limit registers.
- o_decode  output  8*NUM_DEVICES  decode-mode registers.
- o_shutdown_n  output  NUM_DEVICES  shutdown register bit0 (1 = normal operation).
- o_test  output  NUM_DEVICES  display-test register bit0.
- o_load  output  1  1-cycle pulse when a word set is latched.
- o_len_err  output  1  sticky flag: a CS rise occurred with bit count != 16*NUM_DEVICES.

Behaviour:
- Input conditioning:
  - i_cs, i_sck and i_mosi each pass through 2-flop synchronizers, plus one history flop for edge detection.
  - A rising edge is detected 3 clk after the pin edge.
  - i_mosi is sampled in the same cycle the sck rise is detected, giving equal delay on both paths.
- Shift register:
  - sr is 16*NUM_DEVICES bits.
  - On a detected sck rise while synced CS is low: sr <= {sr[16N-2:0], mosi}; bit counter increments, saturating at 16N+1.
  - sck edges while CS is high are ignored.
- CS fall: bit counter clears to 0; sr is left unchanged.
- CS rise (load), acted on in the cycle it is detected:
  - Each device d decodes word w = sr[16d+15:16d]; addr = w[11:8], data = w[7:0]; w[15:12] is ignored.
  - The last word shifted in therefore lands in device 0, and the first word shifted lands in device N-1.
  - addr 0x0: no-op.
  - addr 0x1-0x8: digit[d][addr-1] <= data.
  - addr 0x9: decode <= data.
  - addr 0xA: intensity <= data[3:0].
  - addr 0xB: scan_limit <= data[2:0].
  - addr 0xC: shutdown_n <= data[0].
  - addr 0xD and 0xE: ignored.
  - addr 0xF: test <= data[0].
  - o_load pulses high the following cycle.
  - Latching happens regardless of the bit count, matching silicon.
  - If the bit count != 16N, o_len_err sets; it clears only on reset.
- Read port: o_rd_data <= digit[i_rd_dev][i_rd_row] every clk. An out-of-range i_rd_dev returns 8'h00.
- Simultaneous events:
  - A load in cycle t is visible on o_rd_data for a read address presented in cycle t+1 (output valid at t+2).
  - A read of the same location in cycle t returns the old value.
- Reset (any time, including mid-transfer):
  - sr, bit counter, all digit and control registers, o_rd_data, o_load and o_len_err clear to 0.
  - Synchronizer flops clear to: cs = 1, sck = 0, mosi = 0. No spurious edges are detected after reset.
- No internal FSM besides the load path: IDLE (CS high) -> SHIFT (CS low) -> LOAD (1 cycle) -> IDLE.

Test Plan:
- Init sequence: for each of words 0x0F00, 0x0B07, 0x0900 and 0x0A05, send the word 4x under one CS frame, then raise CS -> for every d: o_test[d]=0, o_scan_limit[d]=7, o_decode[d]=0x00, o_intensity[d]=5; o_load pulses 4 times; o_len_err=0.
- Daisy order: one frame of 0x0181, 0x0142, 0x0124, 0x0118 -> row 0 reads dev3=0x81, dev2=0x42, dev1=0x24, dev0=0x18, each valid 1 cycle after address.
- No-op isolation: frame {0x0000, 0x0000, 0x0000, 0x0855} -> dev0 row7=0x55; rows of dev1-3 unchanged; o_dout tracks sr MSB during shifting.
- Short frame: CS low, 40 sck rises, CS high -> o_len_err=1 and stays set; next full frame still latches correctly.
- Reset mid-transfer: assert reset after 20 bits of a frame, then send a full frame of 0x0C01 x4 -> only the new frame's effects appear, with o_shutdown_n=4'b1111 and all digits 0.
- sck while CS high: toggle sck 16 times with CS high, then CS low/high with no bits -> no register change; o_len_err=1 (count 0).

Source files
------------

// File: rtl/silife_max7219_rx_if.sv
// SPI pin bundle between a MAX7219-style display driver and its receiver model.
interface silife_max7219_rx_if;
    logic i_cs;
    logic i_sck;
    logic i_mosi;
    logic o_dout;

    modport master (output i_cs, output i_sck, output i_mosi, input o_dout);
    modport slave  (input i_cs, input i_sck, input i_mosi, output o_dout);
endinterface

// File: rtl/silife_max7219_rx.sv
// Receiver model of a chain of MAX7219 drivers: shifts SPI words in and decodes
// each device's word into digit/control register state when CS/LOAD rises.
module silife_max7219_rx #(
    parameter int NUM_DEVICES = 4,
    parameter int DEV_W       = (NUM_DEVICES > 1) ? $clog2(NUM_DEVICES) : 1
) (
    input  logic                       clk,
    input  logic                       reset,
    silife_max7219_rx_if.slave         spi,
    input  logic [DEV_W-1:0]           i_rd_dev,
    input  logic [2:0]                 i_rd_row,
    output logic [7:0]                 o_rd_data,
    output logic [4*NUM_DEVICES-1:0]   o_intensity,
    output logic [3*NUM_DEVICES-1:0]   o_scan_limit,
    output logic [8*NUM_DEVICES-1:0]   o_decode,
    output logic [NUM_DEVICES-1:0]     o_shutdown_n,
    output logic [NUM_DEVICES-1:0]     o_test,
    output logic                       o_load,
    output logic                       o_len_err
);
    localparam int SR_W  = 16 * NUM_DEVICES;
    localparam int CNT_W = $clog2(SR_W + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(SR_W);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(SR_W + 1);

    typedef enum logic [1:0] {StIdle, StShift, StLoad} state_e;

    logic r_cs_s1, r_cs_s2, r_cs_h;
    logic r_sck_s1, r_sck_s2, r_sck_h;
    logic r_mosi_s1, r_mosi_s2;
    logic w_sck_rise, w_cs_fall, w_cs_rise, w_shift;

    logic [SR_W-1:0]  r_sr;
    logic [CNT_W-1:0] r_cnt;
    state_e           r_state, w_state_next;

    logic [7:0] r_digit      [NUM_DEVICES][8];
    logic [3:0] r_intensity  [NUM_DEVICES];
    logic [2:0] r_scan_limit [NUM_DEVICES];
    logic [7:0] r_decode     [NUM_DEVICES];
    logic       r_shutdown_n [NUM_DEVICES];
    logic       r_test       [NUM_DEVICES];
    logic [3:0] w_addr       [NUM_DEVICES];
    logic [7:0] w_data       [NUM_DEVICES];
    logic [7:0] r_rd_data;
    logic       r_len_err;

    // Synchronizers reset to the idle bus levels so no edge is seen on release.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cs_s1   <= 1'b1;
            r_cs_s2   <= 1'b1;
            r_cs_h    <= 1'b1;
            r_sck_s1  <= 1'b0;
            r_sck_s2  <= 1'b0;
            r_sck_h   <= 1'b0;
            r_mosi_s1 <= 1'b0;
            r_mosi_s2 <= 1'b0;
        end else begin
            r_cs_s1   <= spi.i_cs;
            r_cs_s2   <= r_cs_s1;
            r_cs_h    <= r_cs_s2;
            r_sck_s1  <= spi.i_sck;
            r_sck_s2  <= r_sck_s1;
            r_sck_h   <= r_sck_s2;
            r_mosi_s1 <= spi.i_mosi;
            r_mosi_s2 <= r_mosi_s1;
        end
    end

    assign w_sck_rise = r_sck_s2 & ~r_sck_h;
    assign w_cs_fall  = ~r_cs_s2 & r_cs_h;
    assign w_cs_rise  = r_cs_s2 & ~r_cs_h;
    assign w_shift    = w_sck_rise & ~r_cs_s2;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sr  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_shift) begin
                r_sr <= {r_sr[SR_W-2:0], r_mosi_s2};
            end
            if (w_cs_fall) begin
                r_cnt <= '0;
            end else if (w_shift && r_cnt != CNT_SAT) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (w_cs_rise) begin
            w_state_next = StLoad;
        end else begin
            unique case (r_state)
                StIdle:  if (!r_cs_s2) w_state_next = StShift;
                StShift: w_state_next = StShift;
                StLoad:  w_state_next = r_cs_s2 ? StIdle : StShift;
                default: w_state_next = StIdle;
            endcase
        end
    end

    always_comb begin
        o_load = (r_state == StLoad);
    end

    // Device d owns word d counted from the DIN end, so the last word sent is device 0.
    always_comb begin
        for (int d = 0; d < NUM_DEVICES; d++) begin
            w_addr[d] = r_sr[16*d+8 +: 4];
            w_data[d] = r_sr[16*d +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int d = 0; d < NUM_DEVICES; d++) begin
                for (int r = 0; r < 8; r++) begin
                    r_digit[d][r] <= '0;
                end
                r_intensity[d]  <= '0;
                r_scan_limit[d] <= '0;
                r_decode[d]     <= '0;
                r_shutdown_n[d] <= 1'b0;
                r_test[d]       <= 1'b0;
            end
        end else if (w_cs_rise) begin
            for (int d = 0; d < NUM_DEVICES; d++) begin
                case (w_addr[d])
                    4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8:
                        r_digit[d][3'(w_addr[d] - 4'd1)] <= w_data[d];
                    4'h9:    r_decode[d]     <= w_data[d];
                    4'hA:    r_intensity[d]  <= w_data[d][3:0];
                    4'hB:    r_scan_limit[d] <= w_data[d][2:0];
                    4'hC:    r_shutdown_n[d] <= w_data[d][0];
                    4'hF:    r_test[d]       <= w_data[d][0];
                    default: ;
                endcase
            end
        end
    end

    // Frames of the wrong length still latch, but are flagged until reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_len_err <= 1'b0;
        end else if (w_cs_rise && r_cnt != CNT_FULL) begin
            r_len_err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_data <= '0;
        end else if (int'(i_rd_dev) < NUM_DEVICES) begin
            r_rd_data <= r_digit[i_rd_dev][i_rd_row];
        end else begin
            r_rd_data <= '0;
        end
    end

    for (genvar g = 0; g < NUM_DEVICES; g++) begin : g_flat
        assign o_intensity[4*g +: 4]  = r_intensity[g];
        assign o_scan_limit[3*g +: 3] = r_scan_limit[g];
        assign o_decode[8*g +: 8]     = r_decode[g];
        assign o_shutdown_n[g]        = r_shutdown_n[g];
        assign o_test[g]              = r_test[g];
    end

    assign spi.o_dout = r_sr[SR_W-1];
    assign o_rd_data  = r_rd_data;
    assign o_len_err  = r_len_err;
endmodule

// File: tb/tb_silife_max7219_rx.sv
// Directed bench for the MAX7219 chain receiver: drives SPI frames and checks
// decoded registers, daisy-chain ordering, DOUT, length errors and reset.
module tb_silife_max7219_rx;
    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  i_rd_dev;
    logic [2:0]  i_rd_row;
    logic [7:0]  o_rd_data;
    logic [15:0] o_intensity;
    logic [11:0] o_scan_limit;
    logic [31:0] o_decode;
    logic [3:0]  o_shutdown_n;
    logic [3:0]  o_test;
    logic        o_load;
    logic        o_len_err;

    int total = 0;
    int bad = 0;
    int load_cnt = 0;
    logic [63:0] tb_sr = '0;

    silife_max7219_rx_if spi_if ();

    silife_max7219_rx #(.NUM_DEVICES(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .spi          (spi_if),
        .i_rd_dev     (i_rd_dev),
        .i_rd_row     (i_rd_row),
        .o_rd_data    (o_rd_data),
        .o_intensity  (o_intensity),
        .o_scan_limit (o_scan_limit),
        .o_decode     (o_decode),
        .o_shutdown_n (o_shutdown_n),
        .o_test       (o_test),
        .o_load       (o_load),
        .o_len_err    (o_len_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (o_load === 1'b1) load_cnt++;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic spi_bit(input logic b);
        spi_if.i_mosi = b;
        spi_if.i_sck  = 1'b0;
        repeat (5) @(negedge clk);
        spi_if.i_sck  = 1'b1;
        repeat (5) @(negedge clk);
        tb_sr = {tb_sr[62:0], b};
        spi_if.i_sck  = 1'b0;
    endtask

    task automatic cs_low();
        spi_if.i_cs = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic cs_high();
        spi_if.i_sck = 1'b0;
        repeat (3) @(negedge clk);
        spi_if.i_cs = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic send_frame(input logic [63:0] data, input int nbits);
        cs_low();
        for (int i = nbits - 1; i >= 0; i--) spi_bit(data[i]);
        cs_high();
    endtask

    task automatic rd(input int dev, input int row, output logic [7:0] data);
        i_rd_dev = 2'(dev);
        i_rd_row = 3'(row);
        @(negedge clk);
        data = o_rd_data;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        spi_if.i_cs = 1'b1;
        spi_if.i_sck = 1'b0;
        spi_if.i_mosi = 1'b0;
        i_rd_dev = '0;
        i_rd_row = '0;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        total++; if (o_rd_data !== 8'h00) begin bad++; $display("FAIL reset_rd: got %h want 00", o_rd_data); end
        total++; if (spi_if.o_dout !== 1'b0) begin bad++; $display("FAIL reset_dout: got %b want 0", spi_if.o_dout); end
        total++; if (o_load !== 1'b0) begin bad++; $display("FAIL reset_load: got %b want 0", o_load); end
        total++; if (o_len_err !== 1'b0) begin bad++; $display("FAIL reset_len_err: got %b want 0", o_len_err); end
        total++; if (o_intensity !== 16'h0 || o_scan_limit !== 12'h0 || o_decode !== 32'h0)
            begin bad++; $display("FAIL reset_ctrl: got %h %h %h want 0 0 0", o_intensity, o_scan_limit, o_decode); end
        total++; if (o_shutdown_n !== 4'h0 || o_test !== 4'h0)
            begin bad++; $display("FAIL reset_bits: got %b %b want 0000 0000", o_shutdown_n, o_test); end
        total++; if (load_cnt !== 0) begin bad++; $display("FAIL reset_spurious_load: got %0d want 0", load_cnt); end
    endtask

    task automatic test_init();
        int l0;
        l0 = load_cnt;
        send_frame({4{16'h0F00}}, 64);
        send_frame({4{16'h0B07}}, 64);
        send_frame({4{16'h0900}}, 64);
        send_frame({4{16'h0A05}}, 64);
        total++; if (o_test !== 4'b0000) begin bad++; $display("FAIL init_test: got %b want 0000", o_test); end
        total++; if (o_scan_limit !== 12'o7777) begin bad++; $display("FAIL init_scan: got %h want fff", o_scan_limit); end
        total++; if (o_decode !== 32'h0) begin bad++; $display("FAIL init_decode: got %h want 0", o_decode); end
        total++; if (o_intensity !== 16'h5555) begin bad++; $display("FAIL init_intensity: got %h want 5555", o_intensity); end
        total++; if (load_cnt - l0 !== 4) begin bad++; $display("FAIL init_loads: got %0d want 4", load_cnt - l0); end
        total++; if (o_len_err !== 1'b0) begin bad++; $display("FAIL init_len_err: got %b want 0", o_len_err); end
    endtask

    task automatic test_daisy();
        logic [7:0] exp [4];
        logic [7:0] v;
        exp = '{8'h18, 8'h24, 8'h42, 8'h81};
        send_frame({16'h0181, 16'h0142, 16'h0124, 16'h0118}, 64);
        for (int d = 3; d >= 0; d--) begin
            rd(d, 0, v);
            total++; if (v !== exp[d]) begin bad++; $display("FAIL daisy_row0_dev%0d: got %h want %h", d, v, exp[d]); end
        end
        total++; if (o_intensity !== 16'h5555) begin bad++; $display("FAIL daisy_ctrl_kept: got %h want 5555", o_intensity); end
    endtask

    task automatic test_noop();
        logic [63:0] data;
        logic [7:0] v;
        data = {16'h0000, 16'h0000, 16'h0000, 16'h0855};
        cs_low();
        for (int i = 63; i >= 0; i--) begin
            spi_bit(data[i]);
            total++; if (spi_if.o_dout !== tb_sr[63]) begin bad++; $display("FAIL noop_dout_bit%0d: got %b want %b", i, spi_if.o_dout, tb_sr[63]); end
        end
        cs_high();
        rd(0, 7, v);
        total++; if (v !== 8'h55) begin bad++; $display("FAIL noop_dev0_row7: got %h want 55", v); end
        rd(0, 0, v);
        total++; if (v !== 8'h18) begin bad++; $display("FAIL noop_dev0_row0: got %h want 18", v); end
        rd(1, 0, v);
        total++; if (v !== 8'h24) begin bad++; $display("FAIL noop_dev1_row0: got %h want 24", v); end
        rd(2, 0, v);
        total++; if (v !== 8'h42) begin bad++; $display("FAIL noop_dev2_row0: got %h want 42", v); end
        rd(3, 0, v);
        total++; if (v !== 8'h81) begin bad++; $display("FAIL noop_dev3_row0: got %h want 81", v); end
        rd(1, 7, v);
        total++; if (v !== 8'h00) begin bad++; $display("FAIL noop_dev1_row7: got %h want 00", v); end
    endtask

    task automatic test_short();
        int l0;
        logic [7:0] v;
        l0 = load_cnt;
        send_frame(64'h0, 40);
        total++; if (o_len_err !== 1'b1) begin bad++; $display("FAIL short_len_err: got %b want 1", o_len_err); end
        total++; if (load_cnt - l0 !== 1) begin bad++; $display("FAIL short_load: got %0d want 1", load_cnt - l0); end
        send_frame({16'h0A01, 16'h0A02, 16'h0A03, 16'h0A04}, 64);
        total++; if (o_intensity !== 16'h1234) begin bad++; $display("FAIL short_next_intensity: got %h want 1234", o_intensity); end
        total++; if (o_len_err !== 1'b1) begin bad++; $display("FAIL short_len_err_sticky: got %b want 1", o_len_err); end
        rd(0, 7, v);
        total++; if (v !== 8'h55) begin bad++; $display("FAIL short_dev0_row7: got %h want 55", v); end
    endtask

    task automatic test_reset_mid();
        int l0;
        logic [7:0] v;
        cs_low();
        for (int i = 0; i < 20; i++) spi_bit(1'b1);
        reset = 1'b1;
        spi_if.i_cs = 1'b1;
        spi_if.i_sck = 1'b0;
        spi_if.i_mosi = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        tb_sr = '0;
        l0 = load_cnt;
        repeat (5) @(negedge clk);
        send_frame({4{16'h0C01}}, 64);
        total++; if (o_shutdown_n !== 4'b1111) begin bad++; $display("FAIL rstmid_shutdown: got %b want 1111", o_shutdown_n); end
        total++; if (o_intensity !== 16'h0 || o_scan_limit !== 12'h0 || o_decode !== 32'h0)
            begin bad++; $display("FAIL rstmid_ctrl: got %h %h %h want 0 0 0", o_intensity, o_scan_limit, o_decode); end
        total++; if (o_test !== 4'b0000) begin bad++; $display("FAIL rstmid_test: got %b want 0000", o_test); end
        total++; if (o_len_err !== 1'b0) begin bad++; $display("FAIL rstmid_len_err: got %b want 0", o_len_err); end
        total++; if (load_cnt - l0 !== 1) begin bad++; $display("FAIL rstmid_load: got %0d want 1", load_cnt - l0); end
        for (int d = 0; d < 4; d++) begin
            for (int r = 0; r < 8; r++) begin
                rd(d, r, v);
                total++; if (v !== 8'h00) begin bad++; $display("FAIL rstmid_digit_d%0d_r%0d: got %h want 00", d, r, v); end
            end
        end
    endtask

    task automatic test_sck_cs_high();
        int l0;
        l0 = load_cnt;
        spi_if.i_mosi = 1'b1;
        for (int i = 0; i < 16; i++) begin
            spi_if.i_sck = 1'b1;
            repeat (5) @(negedge clk);
            spi_if.i_sck = 1'b0;
            repeat (5) @(negedge clk);
        end
        spi_if.i_cs = 1'b0;
        repeat (8) @(negedge clk);
        spi_if.i_cs = 1'b1;
        repeat (10) @(negedge clk);
        total++; if (o_test !== 4'b0000) begin bad++; $display("FAIL sckhigh_test: got %b want 0000", o_test); end
        total++; if (o_shutdown_n !== 4'b1111) begin bad++; $display("FAIL sckhigh_shutdown: got %b want 1111", o_shutdown_n); end
        total++; if (o_len_err !== 1'b1) begin bad++; $display("FAIL sckhigh_len_err: got %b want 1", o_len_err); end
        total++; if (load_cnt - l0 !== 1) begin bad++; $display("FAIL sckhigh_load: got %0d want 1", load_cnt - l0); end
        total++; if (spi_if.o_dout !== tb_sr[63]) begin bad++; $display("FAIL sckhigh_dout: got %b want %b", spi_if.o_dout, tb_sr[63]); end
    endtask

    initial begin
        test_reset();
        test_init();
        test_daisy();
        test_noop();
        test_short();
        test_reset_mid();
        test_sck_cs_high();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
